// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the imem req/ack handshake and feeds IF/ID.
// Optional ack watchdog enabled by defining IF_ACK_TIMEOUT_EN.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction,
   output logic        imem_err
);

   typedef enum logic [1:0] {StFetch, StWait, StReady, StKill} state_e;

   state_e      state_q;
   logic [31:0] pc_q, req_addr_q, ibuf_q, ibuf_pc_q;
   logic [31:0] cur_addr, cur_pc4, branch_tgt;
   logic        req, ack;
   logic        unused_addr_lsb;

   // In FETCH the request is issued from pc directly; req_addr captures it for later cycles.
   assign cur_addr        = (state_q == StFetch) ? pc_q : req_addr_q;
   assign cur_pc4         = cur_addr + 32'd4;
   assign branch_tgt      = {branch_addr[31:2], 2'b00};
   assign unused_addr_lsb = ^branch_addr[1:0];
   assign req             = !rst && (state_q != StReady);
   assign ack             = req && imem_ack;
   assign imem_req        = req;
   assign imem_addr       = cur_addr;

   always_comb begin
      if_valid       = 1'b0;
      if_pc          = 32'h0;
      if_instruction = 32'h0;
      unique case (state_q)
         StFetch, StWait: begin
            if (ack && !freeze && !branch_taken) begin
               if_valid       = 1'b1;
               if_pc          = cur_pc4;
               if_instruction = imem_rdata;
            end
         end
         StReady: begin
            if (!branch_taken) begin
               if_valid       = 1'b1;
               if_pc          = ibuf_pc_q;
               if_instruction = ibuf_q;
            end
         end
         StKill: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StFetch;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         ibuf_q     <= 32'h0;
         ibuf_pc_q  <= 32'h0;
      end else begin
         unique case (state_q)
            StFetch, StWait: begin
               if (state_q == StFetch) req_addr_q <= pc_q;
               if (branch_taken) begin
                  pc_q    <= branch_tgt;
                  state_q <= ack ? StFetch : StKill;
               end else if (ack) begin
                  if (freeze) begin
                     ibuf_q    <= imem_rdata;
                     ibuf_pc_q <= cur_pc4;
                     state_q   <= StReady;
                  end else begin
                     pc_q    <= cur_pc4;
                     state_q <= StFetch;
                  end
               end else begin
                  state_q <= StWait;
               end
            end
            StReady: begin
               if (branch_taken) begin
                  pc_q    <= branch_tgt;
                  state_q <= StFetch;
               end else if (!freeze) begin
                  pc_q    <= ibuf_pc_q;
                  state_q <= StFetch;
               end
            end
            StKill: begin
               // Stale request still in flight; pc already holds the redirect target.
               if (branch_taken) pc_q <= branch_tgt;
               if (ack) state_q <= StFetch;
            end
         endcase
      end
   end

`ifdef IF_ACK_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] wait_cnt_q, wait_cnt_inc;
   logic            err_q;

   // A FETCH cycle is the first cycle of a fresh request, so counting restarts at one.
   assign wait_cnt_inc = (state_q == StFetch) ? CntW'(1) :
                         (wait_cnt_q == TimeoutVal) ? wait_cnt_q : wait_cnt_q + CntW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else if (!req || imem_ack) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_inc;
         if (wait_cnt_inc == TimeoutVal) err_q <= 1'b1;
      end
   end

   assign imem_err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign imem_err       = 1'b0;
`endif

endmodule
